// File: rtl/fetch_ctrl_pkg.sv
// Shared encodings for the fetch sequencer: FSM states, per-stage stall codes and
// chip-enable levels.
package fetch_ctrl_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } fetch_state_e;

    // Stall vector bits: [0]=pc [1]=if [2]=id [3]=ex [4]=mem [5]=wb
    localparam int unsigned STALL_CODE_W = 6;
    localparam logic [STALL_CODE_W-1:0] STALL_NONE = 6'b000000;
    localparam logic [STALL_CODE_W-1:0] STALL_IF   = 6'b000011;
    localparam logic [STALL_CODE_W-1:0] STALL_ID   = 6'b000111;
    localparam logic [STALL_CODE_W-1:0] STALL_EX   = 6'b001111;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating 32-bit event counter used to profile fetch stall cycles
// (only instantiated when FETCH_PERF_EN is defined).
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_inc,
    output logic [31:0] o_cnt
);

    logic [31:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 32'h0000_0000;
        end else if (i_inc && (r_cnt != 32'hFFFF_FFFF)) begin
            r_cnt <= r_cnt + 32'd1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_ctrl.sv
// PC / instruction-fetch sequencer: arbitrates exception, stall, imem-wait and branch
// redirects. Define FETCH_PERF_EN to add the perf_stall_cnt stall-cycle counter output.
module fetch_ctrl
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned          ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC = '0,
    parameter int unsigned          STALL_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_id_i,
    input  logic               stallreq_ex_i,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               excp_flag_i,
    input  logic [ADDR_W-1:0]  excp_pc_i,
    input  logic               inst_ack_i,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce,
    output logic               inst_req_o,
    output logic [STALL_W-1:0] stall,
    output logic               flush
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_stall_cnt
`endif
);

    fetch_state_e      r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_pc, w_pc_nxt;
    logic              r_ce, w_ce_nxt;
    logic              r_flush, w_flush_nxt;
    logic              r_pend, w_pend_nxt;
    logic [ADDR_W-1:0] r_pend_tgt, w_pend_tgt_nxt;
    logic [STALL_W-1:0] w_stall;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_excp_tgt;
    logic              w_unused;

    // Redirect targets are always word aligned.
    assign w_branch_tgt = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign w_excp_tgt   = {excp_pc_i[ADDR_W-1:2], 2'b00};
    assign w_unused     = ^{branch_target_i[1:0], excp_pc_i[1:0]};

    assign inst_req_o = r_ce && (r_state == S_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_RESET;
            r_pc       <= RESET_PC;
            r_ce       <= CHIP_DISABLE;
            r_flush    <= 1'b0;
            r_pend     <= 1'b0;
            r_pend_tgt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_ce       <= w_ce_nxt;
            r_flush    <= w_flush_nxt;
            r_pend     <= w_pend_nxt;
            r_pend_tgt <= w_pend_tgt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_ce_nxt       = r_ce;
        w_flush_nxt    = 1'b0;
        w_pend_nxt     = r_pend;
        w_pend_tgt_nxt = r_pend_tgt;
        w_stall        = STALL_W'(STALL_NONE);

        unique case (r_state)
            S_RESET: begin
                w_state_nxt = S_RUN;
                w_ce_nxt    = CHIP_ENABLE;
            end
            S_RUN: begin
                if (excp_flag_i) begin
                    w_pc_nxt    = w_excp_tgt;
                    w_flush_nxt = 1'b1;
                    w_pend_nxt  = 1'b0;
                    w_state_nxt = S_FLUSH;
                end else begin
                    if (stallreq_ex_i) begin
                        w_stall = STALL_W'(STALL_EX);
                    end else if (stallreq_id_i) begin
                        w_stall = STALL_W'(STALL_ID);
                    end else if (inst_req_o && !inst_ack_i) begin
                        w_stall = STALL_W'(STALL_IF);
                    end

                    // While held, a resolved branch is parked until the pipe frees up.
                    if (w_stall != '0) begin
                        if (branch_flag_i) begin
                            w_pend_nxt     = 1'b1;
                            w_pend_tgt_nxt = w_branch_tgt;
                        end
                    end else if (branch_flag_i) begin
                        w_pc_nxt   = w_branch_tgt;
                        w_pend_nxt = 1'b0;
                    end else if (r_pend) begin
                        w_pc_nxt   = r_pend_tgt;
                        w_pend_nxt = 1'b0;
                    end else begin
                        w_pc_nxt = r_pc + ADDR_W'(4);
                    end
                end
            end
            S_FLUSH: begin
                if (excp_flag_i) begin
                    w_pc_nxt    = w_excp_tgt;
                    w_flush_nxt = 1'b1;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            default: begin
                w_state_nxt = S_RESET;
            end
        endcase
    end

    assign pc    = r_pc;
    assign ce    = r_ce;
    assign flush = r_flush;
    assign stall = w_stall;

`ifdef FETCH_PERF_EN
    logic w_perf_inc;

    assign w_perf_inc = (r_state == S_RUN) && (w_stall != '0);

    fetch_perf_cnt u_perf_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_perf_inc),
        .o_cnt (perf_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl: reset, sequential fetch, imem wait,
// branch under stall, exception over stall, PC wrap and reset during flush.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_id_i = 1'b0;
    logic        stallreq_ex_i = 1'b0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = 32'h0;
    logic        excp_flag_i = 1'b0;
    logic [31:0] excp_pc_i = 32'h0;
    logic        inst_ack_i = 1'b1;
    logic [31:0] pc;
    logic        ce;
    logic        inst_req_o;
    logic [5:0]  stall;
    logic        flush;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fetch_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .stallreq_id_i   (stallreq_id_i),
        .stallreq_ex_i   (stallreq_ex_i),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .excp_flag_i     (excp_flag_i),
        .excp_pc_i       (excp_pc_i),
        .inst_ack_i      (inst_ack_i),
        .pc              (pc),
        .ce              (ce),
        .inst_req_o      (inst_req_o),
        .stall           (stall),
        .flush           (flush)
`ifdef FETCH_PERF_EN
        ,
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1 rst = 1'b1;
        #10;
        check("rst_pc", pc, 32'h0);
        check("rst_ce", {31'h0, ce}, 32'h0);
        check("rst_flush", {31'h0, flush}, 32'h0);
        check("rst_stall", {26'h0, stall}, 32'h0);
        check("rst_req", {31'h0, inst_req_o}, 32'h0);

        @(negedge clk);
        rst = 1'b0;
        step();
        check("rel_ce", {31'h0, ce}, 32'h1);
        check("rel_pc", pc, 32'h0);
        check("rel_req", {31'h0, inst_req_o}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            step();
            check("seq_pc", pc, 32'(i * 4));
        end

        // Imem wait at 0x10
        inst_ack_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 check("wait_stall", {26'h0, stall}, 32'h03);
            step();
            check("wait_pc", pc, 32'h10);
        end
        inst_ack_i = 1'b1;
        #1 check("ack_stall", {26'h0, stall}, 32'h0);
        step();
        check("ack_pc", pc, 32'h14);
        step();
        step();
        step();
        check("pre_br_pc", pc, 32'h20);

        // Branch while ID stalls
        stallreq_id_i = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h200;
        #1 check("id_stall", {26'h0, stall}, 32'h07);
        step();
        check("id_hold_pc", pc, 32'h20);
        stallreq_id_i = 1'b0;
        branch_flag_i = 1'b0;
        branch_target_i = 32'h999;
        #1 check("free_stall", {26'h0, stall}, 32'h0);
        step();
        check("pend_pc", pc, 32'h200);

        // Pending target overridden by a live (misaligned) branch
        stallreq_ex_i = 1'b1;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h300;
        #1 check("ex_stall", {26'h0, stall}, 32'h0F);
        step();
        check("ex_hold_pc", pc, 32'h200);
        stallreq_ex_i = 1'b0;
        branch_target_i = 32'h407;
        step();
        check("live_br_pc", pc, 32'h404);
        branch_flag_i = 1'b0;
        step();
        check("pend_clr_pc", pc, 32'h408);

        // Exception beats EX stall
        excp_flag_i = 1'b1;
        excp_pc_i = 32'h180;
        stallreq_ex_i = 1'b1;
        step();
        excp_flag_i = 1'b0;
        check("excp_pc", pc, 32'h180);
        check("excp_flush", {31'h0, flush}, 32'h1);
        #1 check("flush_stall", {26'h0, stall}, 32'h0);
        check("flush_req", {31'h0, inst_req_o}, 32'h0);
        stallreq_ex_i = 1'b0;
        step();
        check("flush_end", {31'h0, flush}, 32'h0);
        check("post_flush_pc", pc, 32'h180);
        step();
        check("handler_pc", pc, 32'h184);

        // PC wrap
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        step();
        branch_flag_i = 1'b0;
        check("top_pc", pc, 32'hFFFF_FFFC);
        step();
        check("wrap_pc", pc, 32'h0);

        // Asynchronous reset during S_FLUSH
        excp_flag_i = 1'b1;
        excp_pc_i = 32'h40;
        step();
        excp_flag_i = 1'b0;
        check("f2_flush", {31'h0, flush}, 32'h1);
        check("f2_pc", pc, 32'h40);
        #1 rst = 1'b1;
        #1;
        check("mrst_flush", {31'h0, flush}, 32'h0);
        check("mrst_ce", {31'h0, ce}, 32'h0);
        check("mrst_pc", pc, 32'h0);
        check("mrst_req", {31'h0, inst_req_o}, 32'h0);
        rst = 1'b0;
        step();
        check("mrel_ce", {31'h0, ce}, 32'h1);
        step();
        check("mrel_pc", pc, 32'h4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
